// File: rtl/pps_sec_pulse_gen.sv
// Turns the asynchronous external 1PPS into a one-cycle second strobe in the clk domain,
// with period/tolerance validation, glitch rejection and optional synthetic holdover pulses.
module pps_sec_pulse_gen #(
  parameter int SYNC_STAGES = 3,
  parameter int CNT_W       = 32,
  parameter int STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pps_in,
  input  logic              cfg_en,
  input  logic              cfg_falling,
  input  logic              cfg_holdover,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [STAT_W-1:0] cfg_tol,
  output logic              sec_pulse_ed,
  output logic              pulse_synth,
  output logic              pps_valid,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  period_meas,
  output logic [STAT_W-1:0] missed_cnt,
  output logic [STAT_W-1:0] glitch_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } state_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W:0]         per_q, per_d, lo_q, lo_d, hi_q, hi_d;
  logic                   pulse_q, pulse_d;
  logic                   synth_q, synth_d;
  logic                   valid_q, valid_d;
  logic [CNT_W-1:0]       meas_q, meas_d;
  logic [STAT_W-1:0]      missed_q, missed_d;
  logic [STAT_W-1:0]      glitch_q, glitch_d;

  logic [CNT_W:0]         tol_ext_s;
  logic [CNT_W:0]         ivl_s;
  logic                   edge_s;
  logic                   pulse_ok_s;
  logic                   in_win_s;

  // Synchroniser, edge detect and registered acceptance window
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], pps_in};
    dly_d     = sync_q[SYNC_STAGES-1];
    edge_s    = cfg_falling ? (~sync_q[SYNC_STAGES-1] & dly_q)
                            : (sync_q[SYNC_STAGES-1] & ~dly_q);
    tol_ext_s = {{(CNT_W+1-STAT_W){1'b0}}, cfg_tol};
    per_d     = (cfg_period == {CNT_W{1'b0}}) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, cfg_period};
    lo_d      = (per_d > tol_ext_s) ? (per_d - tol_ext_s) : {{CNT_W{1'b0}}, 1'b1};
    hi_d      = per_d + tol_ext_s;
    ivl_s     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    in_win_s  = (ivl_s >= lo_q) && (ivl_s <= hi_q);
    // a pulse in the previous cycle blocks a new one, so the strobe is never back-to-back
    pulse_ok_s = ~pulse_q;
  end

  // Lock state machine, strobe generation and statistics
  always_comb begin
    state_d  = state_q;
    pulse_d  = 1'b0;
    synth_d  = 1'b0;
    valid_d  = valid_q;
    meas_d   = meas_q;
    missed_d = missed_q;
    glitch_d = glitch_q;
    if (!cfg_en) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          valid_d = 1'b0;
        end
        ACQUIRE: begin
          if (edge_s && pulse_ok_s) begin
            pulse_d = 1'b1;
            state_d = LOCKED;
            valid_d = 1'b0;
          end else begin
            state_d = ACQUIRE;
          end
        end
        LOCKED: begin
          if (edge_s && in_win_s && pulse_ok_s) begin
            pulse_d = 1'b1;
            meas_d  = ivl_s[CNT_W] ? {CNT_W{1'b1}} : ivl_s[CNT_W-1:0];
            valid_d = 1'b1;
          end else if (edge_s && (ivl_s < lo_q)) begin
            glitch_d = sat_inc(glitch_q);
          end else if ((ivl_s >= hi_q) && pulse_ok_s) begin
            valid_d = 1'b0;
            if (cfg_holdover) begin
              pulse_d  = 1'b1;
              synth_d  = 1'b1;
              missed_d = sat_inc(missed_q);
              state_d  = HOLDOVER;
            end else begin
              state_d = ACQUIRE;
            end
          end else begin
            state_d = LOCKED;
          end
        end
        HOLDOVER: begin
          if (edge_s && pulse_ok_s) begin
            pulse_d = 1'b1;
            valid_d = 1'b0;
            state_d = LOCKED;
          end else if ((ivl_s >= per_q) && pulse_ok_s) begin
            pulse_d  = 1'b1;
            synth_d  = 1'b1;
            missed_d = sat_inc(missed_q);
          end else begin
            state_d = HOLDOVER;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
    if (!cfg_en || (state_q == IDLE) || pulse_d) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      dly_q    <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      per_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      pulse_q  <= 1'b0;
      synth_q  <= 1'b0;
      valid_q  <= 1'b0;
      meas_q   <= '0;
      missed_q <= '0;
      glitch_q <= '0;
    end else begin
      sync_q   <= sync_d;
      dly_q    <= dly_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      pulse_q  <= pulse_d;
      synth_q  <= synth_d;
      valid_q  <= valid_d;
      meas_q   <= meas_d;
      missed_q <= missed_d;
      glitch_q <= glitch_d;
    end
  end

  assign sec_pulse_ed = pulse_q;
  assign pulse_synth  = synth_q;
  assign pps_valid    = valid_q;
  assign state        = state_q;
  assign period_meas  = meas_q;
  assign missed_cnt   = missed_q;
  assign glitch_cnt   = glitch_q;

endmodule

// File: tb/tb_pps_sec_pulse_gen.sv
// Directed bench for pps_sec_pulse_gen: expected strobe cycles are queued when PPS edges
// are driven (or synthetic slots are predicted) and matched as the strobes appear.
module tb_pps_sec_pulse_gen;
  localparam int SS     = 3;
  localparam int CNT_W  = 32;
  localparam int STAT_W = 16;

  logic              clk;
  logic              rst;
  logic              pps_in;
  logic              cfg_en;
  logic              cfg_falling;
  logic              cfg_holdover;
  logic [CNT_W-1:0]  cfg_period;
  logic [STAT_W-1:0] cfg_tol;
  logic              sec_pulse_ed;
  logic              pulse_synth;
  logic              pps_valid;
  logic [1:0]        state;
  logic [CNT_W-1:0]  period_meas;
  logic [STAT_W-1:0] missed_cnt;
  logic [STAT_W-1:0] glitch_cnt;

  pps_sec_pulse_gen #(.SYNC_STAGES(SS), .CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .pps_in(pps_in), .cfg_en(cfg_en), .cfg_falling(cfg_falling),
    .cfg_holdover(cfg_holdover), .cfg_period(cfg_period), .cfg_tol(cfg_tol),
    .sec_pulse_ed(sec_pulse_ed), .pulse_synth(pulse_synth), .pps_valid(pps_valid),
    .state(state), .period_meas(period_meas), .missed_cnt(missed_cnt), .glitch_cnt(glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic synth;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   passes;
  int   last_rise;
  int   p_ref;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge and scoreboarded.
  task automatic tick();
    int   exp_c;
    logic exp_s;
    @(posedge clk);
    #1;
    cyc++;
    if (sec_pulse_ed) begin
      exp_c = -1;
      exp_s = 1'b0;
      if (sb.size() != 0) begin
        exp_c = sb[0].cyc;
        exp_s = sb[0].synth;
        void'(sb.pop_front());
      end
      chk("pulse_cycle", cyc, exp_c);
      chk("pulse_synth", pulse_synth, exp_s);
    end else begin
      chk("synth_without_pulse", pulse_synth, 1'b0);
      if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        chk("pulse_present", sec_pulse_ed, 1'b1);
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Rising PPS edge now, high for hi_len cycles; returns gap cycles after the rise.
  task automatic pps_rise(input int gap, input int hi_len, input bit exp_pulse);
    pps_in    = 1'b1;
    last_rise = cyc;
    if (exp_pulse) sb.push_back('{cyc + SS + 1, 1'b0});
    run(hi_len);
    pps_in = 1'b0;
    run(gap - hi_len);
  endtask

  initial begin
    cyc = 0; checks = 0; passes = 0; last_rise = 0; p_ref = 0;
    rst = 1'b1; pps_in = 1'b0; cfg_en = 1'b0; cfg_falling = 1'b0; cfg_holdover = 1'b0;
    cfg_period = 32'd100; cfg_tol = 16'd2;
    run(3);
    chk("rst_pulse", sec_pulse_ed, 1'b0);
    chk("rst_state", state, 2'd0);
    chk("rst_valid", pps_valid, 1'b0);
    chk("rst_meas", period_meas, 32'd0);
    chk("rst_missed", missed_cnt, 16'd0);
    chk("rst_glitch", glitch_cnt, 16'd0);
    rst = 1'b0;
    run(2);
    chk("idle_when_disabled", state, 2'd0);
    cfg_en = 1'b1;
    run(1);
    chk("acquire_after_enable", state, 2'd1);
    run(5);

    // Lock at 100-cycle period, then tolerance boundaries and a glitch
    pps_rise(100, 10, 1'b1);
    chk("locked_after_first", state, 2'd2);
    chk("valid_after_first", pps_valid, 1'b0);
    pps_rise(100, 10, 1'b1);
    chk("valid_after_second", pps_valid, 1'b1);
    chk("meas_100", period_meas, 32'd100);
    pps_rise(98, 10, 1'b1);
    pps_rise(102, 10, 1'b1);
    chk("meas_98", period_meas, 32'd98);
    pps_rise(97, 10, 1'b1);
    chk("meas_102", period_meas, 32'd102);
    pps_rise(3, 1, 1'b0);
    cfg_holdover = 1'b1;
    pps_rise(50, 10, 1'b1);
    chk("glitch_count", glitch_cnt, 16'd1);
    chk("meas_after_glitch", period_meas, 32'd100);
    chk("valid_after_glitch", pps_valid, 1'b1);
    chk("locked_after_glitch", state, 2'd2);

    // PPS loss with holdover: first synthetic at ivl=102, then every 100
    p_ref = last_rise + SS + 1;
    sb.push_back('{p_ref + 102, 1'b1});
    sb.push_back('{p_ref + 202, 1'b1});
    sb.push_back('{p_ref + 302, 1'b1});
    run(p_ref + 150 - cyc);
    chk("holdover_state", state, 2'd3);
    chk("holdover_valid", pps_valid, 1'b0);
    chk("missed_1", missed_cnt, 16'd1);
    run(p_ref + 339 - cyc);
    chk("missed_3", missed_cnt, 16'd3);

    // Recovery at arbitrary phase
    pps_rise(100, 10, 1'b1);
    chk("recover_state", state, 2'd2);
    chk("recover_valid_low", pps_valid, 1'b0);
    pps_rise(100, 10, 1'b1);
    chk("recover_valid_high", pps_valid, 1'b1);
    chk("recover_meas", period_meas, 32'd100);
    chk("recover_missed", missed_cnt, 16'd3);

    // Loss without holdover: back to ACQUIRE silently
    cfg_holdover = 1'b0;
    p_ref = last_rise + SS + 1;
    run(p_ref + 110 - cyc);
    chk("nohold_state", state, 2'd1);
    chk("nohold_valid", pps_valid, 1'b0);
    chk("nohold_missed", missed_cnt, 16'd3);
    pps_rise(60, 10, 1'b1);
    chk("reacquire_state", state, 2'd2);

    // Disable: IDLE, no pulses, statistics held
    cfg_en = 1'b0;
    run(1);
    chk("disable_state", state, 2'd0);
    chk("disable_valid", pps_valid, 1'b0);
    run(5);
    pps_rise(40, 10, 1'b0);
    chk("disable_missed", missed_cnt, 16'd3);
    chk("disable_glitch", glitch_cnt, 16'd1);
    chk("disable_meas", period_meas, 32'd100);

    // Asynchronous reset between pulses
    cfg_en = 1'b1;
    run(3);
    pps_rise(100, 10, 1'b1);
    pps_rise(50, 10, 1'b1);
    chk("pre_reset_valid", pps_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_state", state, 2'd0);
    chk("async_rst_valid", pps_valid, 1'b0);
    chk("async_rst_meas", period_meas, 32'd0);
    chk("async_rst_missed", missed_cnt, 16'd0);
    chk("async_rst_glitch", glitch_cnt, 16'd0);
    run(3);
    rst = 1'b0;

    // Falling-edge epoch
    cfg_falling = 1'b1;
    run(3);
    for (int k = 0; k < 2; k++) begin
      pps_in = 1'b1;
      run(30);
      pps_in = 1'b0;
      sb.push_back('{cyc + SS + 1, 1'b0});
      run(70);
    end
    chk("falling_state", state, 2'd2);
    chk("falling_valid", pps_valid, 1'b1);
    chk("falling_meas", period_meas, 32'd100);
    run(20);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
